sram_ctrl: RTL and testbench

- Synchronous initiator for the asynchronous SRAM bus: active-low _OE, active-low _WE, address, bidirectional data.
- Converts a single-request valid/ready command interface from the CPU/datapath side into correctly sequenced SRAM read and write cycles.
- Returns read data, or write completion, through a one-cycle response strobe.
- Sits between the control logic and the external RAM; it is the only driver of the SRAM control pins.

---
 rtl/sram_ctrl.sv | 140 ++++++++++++++
 tb/tb_sram_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// Synchronous initiator for an asynchronous SRAM: turns one valid/ready command
// into a sequenced read or write cycle on _OE/_WE/addr/d and a one-cycle response.
module sram_ctrl #(
  parameter int AWIDTH    = 8,
  parameter int DWIDTH    = 8,
  parameter int WR_CYCLES = 1,
  parameter int RD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              _OE,
  output logic              _WE,
  output logic [AWIDTH-1:0] addr,
  inout  wire  [DWIDTH-1:0] d
);

  localparam int CMAX = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WSETUP  = 3'd1,
    WPULSE  = 3'd2,
    WHOLD   = 3'd3,
    RACTIVE = 3'd4,
    RDONE   = 3'd5
  } state_t;

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic              ready_r;
  logic              rsp_valid_r;
  logic              rsp_write_r;
  logic [DWIDTH-1:0] rdata_r;
  logic              oe_n_r;
  logic              we_n_r;
  logic [AWIDTH-1:0] addr_r;
  logic [DWIDTH-1:0] wdata_r;
  logic              drive_r;

  assign req_ready = ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_write = rsp_write_r;
  assign rsp_rdata = rdata_r;
  assign _OE       = oe_n_r;
  assign _WE       = we_n_r;
  assign addr      = addr_r;
  // d is released whenever drive_r drops, including asynchronously on reset
  assign d         = drive_r ? wdata_r : {DWIDTH{1'bz}};

  // Command sequencer: all SRAM pins and response outputs come straight from flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      ready_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      rdata_r     <= {DWIDTH{1'b0}};
      oe_n_r      <= 1'b1;
      we_n_r      <= 1'b1;
      addr_r      <= {AWIDTH{1'b0}};
      wdata_r     <= {DWIDTH{1'b0}};
      drive_r     <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid && ready_r) begin
            ready_r <= 1'b0;
            addr_r  <= req_addr;
            if (req_we) begin
              wdata_r <= req_wdata;
              drive_r <= 1'b1;
              state_r <= WSETUP;
            end else begin
              oe_n_r  <= 1'b0;
              cnt_r   <= CW'(RD_CYCLES - 1);
              state_r <= RACTIVE;
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        WSETUP: begin
          we_n_r  <= 1'b0;
          cnt_r   <= CW'(WR_CYCLES - 1);
          state_r <= WPULSE;
        end
        WPULSE: begin
          if (cnt_r == {CW{1'b0}}) begin
            we_n_r      <= 1'b1;
            rsp_valid_r <= 1'b1;
            rsp_write_r <= 1'b1;
            state_r     <= WHOLD;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        WHOLD: begin
          drive_r <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        RACTIVE: begin
          if (cnt_r == {CW{1'b0}}) begin
            rdata_r     <= d;
            oe_n_r      <= 1'b1;
            rsp_valid_r <= 1'b1;
            rsp_write_r <= 1'b0;
            state_r     <= RDONE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        RDONE: begin
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          // Unreachable encodings fall back to a safe idle with both strobes high
          state_r <= IDLE;
          ready_r <= 1'b0;
          oe_n_r  <= 1'b1;
          we_n_r  <= 1'b1;
          drive_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: a default instance and a WR_CYCLES=3/RD_CYCLES=1 instance,
// each attached to a behavioural asynchronous SRAM.
module tb_sram_ctrl;

  localparam int WR0 = 1, RD0 = 2, WR1 = 3, RD1 = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       req_valid0, req_we0, req_ready0, rsp_valid0, rsp_write0, oe0, we0;
  logic [7:0] req_addr0, req_wdata0, rsp_rdata0, addr0;
  wire  [7:0] d0;
  logic       req_valid1, req_we1, req_ready1, rsp_valid1, rsp_write1, oe1, we1;
  logic [7:0] req_addr1, req_wdata1, rsp_rdata1, addr1;
  wire  [7:0] d1;

  sram_ctrl #(.AWIDTH(8), .DWIDTH(8), .WR_CYCLES(WR0), .RD_CYCLES(RD0)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we0), .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_write(rsp_write0), .rsp_rdata(rsp_rdata0),
    ._OE(oe0), ._WE(we0), .addr(addr0), .d(d0));

  sram_ctrl #(.AWIDTH(8), .DWIDTH(8), .WR_CYCLES(WR1), .RD_CYCLES(RD1)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we1), .req_addr(req_addr1), .req_wdata(req_wdata1),
    .rsp_valid(rsp_valid1), .rsp_write(rsp_write1), .rsp_rdata(rsp_rdata1),
    ._OE(oe1), ._WE(we1), .addr(addr1), .d(d1));

  // Asynchronous SRAMs: read data appears while _OE is low, write latches on _WE rising
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  bit         model_on;
  assign d0 = (!oe0) ? mem0[addr0] : 8'bz;
  assign d1 = (!oe1) ? mem1[addr1] : 8'bz;
  always @(posedge we0) if (model_on) mem0[addr0] = d0;
  always @(posedge we1) if (model_on) mem1[addr1] = d1;

  int pass_cnt = 0;
  int total_cnt = 0;
  int mon_err = 0;

  // Reference model: what the memory should hold and what rsp_rdata should show
  logic [7:0] ref_mem [256];
  logic [7:0] last_rd;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic int mon_chk(input string tag, input logic oe, input logic we,
                                 input logic rdy, input logic po, input logic pw);
    int n;
    n = 0;
    if (!oe && !we) begin n++; $display("FAIL %s both_low: _OE=%0b _WE=%0b", tag, oe, we); end
    if ((!oe && pw) || (!we && po)) begin
      n++; $display("FAIL %s strobe_gap: no high cycle between strobes", tag);
    end
    if ((!oe || !we) && rdy) begin n++; $display("FAIL %s ready_busy: req_ready=1 during strobe", tag); end
    return n;
  endfunction

  logic po0 = 1'b0, pw0 = 1'b0, po1 = 1'b0, pw1 = 1'b0;
  // Per-cycle invariant monitor on both instances
  always @(negedge clk) begin
    if (!reset) begin
      mon_err <= mon_err + mon_chk("u0", oe0, we0, req_ready0, po0, pw0)
                         + mon_chk("u1", oe1, we1, req_ready1, po1, pw1);
    end
    po0 <= !oe0 && !reset;
    pw0 <= !we0 && !reset;
    po1 <= !oe1 && !reset;
    pw1 <= !we1 && !reset;
  end

  task automatic drive(input int k, input logic v, input logic w,
                       input logic [7:0] a, input logic [7:0] wd);
    if (k == 0) begin req_valid0 = v; req_we0 = w; req_addr0 = a; req_wdata0 = wd; end
    else        begin req_valid1 = v; req_we1 = w; req_addr1 = a; req_wdata1 = wd; end
  endtask

  task automatic sample(input int k, output logic rdy, output logic sv, output logic sw,
                        output logic oe, output logic we, output logic [7:0] rd,
                        output logic [7:0] ad, output logic [7:0] dd);
    if (k == 0) begin rdy = req_ready0; sv = rsp_valid0; sw = rsp_write0; oe = oe0; we = we0;
                      rd = rsp_rdata0; ad = addr0; dd = d0; end
    else        begin rdy = req_ready1; sv = rsp_valid1; sw = rsp_write1; oe = oe1; we = we1;
                      rd = rsp_rdata1; ad = addr1; dd = d1; end
  endtask

  // One command from the current negedge; returns at the negedge of its response
  task automatic cmd(input int k, input logic w, input logic [7:0] a, input logic [7:0] wd,
                     input logic [7:0] exp_rd, input bit drop);
    logic rdy, sv, sw, oe, we;
    logic [7:0] rd, ad, dd;
    int wr, rdc, n, wl, ol;
    bit acc, done, dbad, abad;
    wr  = (k == 0) ? WR0 : WR1;
    rdc = (k == 0) ? RD0 : RD1;
    drive(k, 1'b1, w, a, wd);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      sample(k, rdy, sv, sw, oe, we, rd, ad, dd);
      acc = rdy;
      @(negedge clk);
    end
    check("accept", int'(acc), 1);
    if (!acc) begin drive(k, 1'b0, w, a, wd); return; end
    if (drop) drive(k, 1'b0, w, a, wd);
    done = 1'b0; dbad = 1'b0; abad = 1'b0; wl = 0; ol = 0;
    for (n = 1; n <= 20; n++) begin
      sample(k, rdy, sv, sw, oe, we, rd, ad, dd);
      if (!we) wl++;
      if (!oe) ol++;
      if (w && dd != wd) dbad = 1'b1;
      if ((!we || !oe || w) && ad != a) abad = 1'b1;
      if (sv) begin done = 1'b1; break; end
      @(negedge clk);
    end
    check("rsp_seen", int'(done), 1);
    check("latency", n, w ? wr + 2 : rdc + 1);
    check("rsp_write", int'(sw), int'(w));
    check("rsp_rdata", int'(rd), int'(exp_rd));
    check("we_low_cycles", wl, w ? wr : 0);
    check("oe_low_cycles", ol, w ? 0 : rdc);
    check("d_during_write", int'(dbad), 0);
    check("addr_stable", int'(abad), 0);
  endtask

  task automatic model_apply(input logic w, input logic [7:0] a, input logic [7:0] wd);
    if (w) ref_mem[a] = wd;
    else   last_rd = ref_mem[a];
  endtask

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    bit         drop;
  } vec_t;
  vec_t tbl [7];

  initial begin
    logic       w, rdy, sv, sw, oe, we;
    logic [7:0] a, wd, exp, rd, ad, dd;
    bit         hit, saw_rsp;

    tbl[0] = '{1'b1, 8'h12, 8'hA5, 8'h00, 1'b1};
    tbl[1] = '{1'b0, 8'h12, 8'h00, 8'hA5, 1'b1};
    tbl[2] = '{1'b0, 8'h13, 8'h00, 8'h00, 1'b1};
    tbl[3] = '{1'b1, 8'h01, 8'h11, 8'h00, 1'b0};
    tbl[4] = '{1'b1, 8'h02, 8'h22, 8'h00, 1'b0};
    tbl[5] = '{1'b0, 8'h01, 8'h00, 8'h11, 1'b0};
    tbl[6] = '{1'b0, 8'h02, 8'h00, 8'h22, 1'b1};

    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00; mem1[i] = 8'h00; ref_mem[i] = 8'h00;
    end
    last_rd = 8'h00;
    model_on = 1'b0;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_oe", int'(oe0), 1);
    check("rst_we", int'(we0), 1);
    check("rst_ready", int'(req_ready0), 0);
    check("rst_rsp_valid", int'(rsp_valid0), 0);
    check("rst_rsp_rdata", int'(rsp_rdata0), 0);
    check("rst_addr", int'(addr0), 0);
    reset = 1'b0;
    model_on = 1'b1;
    @(negedge clk);
    check("ready_after_rst", int'(req_ready0), 1);
    check("ready_after_rst_u1", int'(req_ready1), 1);
    check("no_rsp_after_rst", int'(rsp_valid0), 0);

    for (int i = 0; i < 7; i++) begin
      cmd(0, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].exp_rd, tbl[i].drop);
      model_apply(tbl[i].w, tbl[i].a, tbl[i].wd);
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);

    cmd(1, 1'b1, 8'hFF, 8'h3C, 8'h00, 1'b1);
    cmd(1, 1'b0, 8'hFF, 8'h00, 8'h3C, 1'b1);
    cmd(1, 1'b1, 8'h00, 8'hC3, 8'h3C, 1'b0);
    cmd(1, 1'b0, 8'h00, 8'h00, 8'hC3, 1'b1);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      w  = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      wd = 8'($urandom);
      exp = w ? last_rd : ref_mem[a];
      cmd(0, w, a, wd, exp, 1'($urandom_range(0, 1)));
      model_apply(w, a, wd);
      if (!req_valid0) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);

    // Reset in the middle of the write pulse
    drive(0, 1'b1, 1'b1, 8'h40, 8'h5A);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (!we0) hit = 1'b1;
    end
    check("reached_wpulse", int'(hit), 1);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    check("async_we_release", int'(we0), 1);
    check("async_oe_high", int'(oe0), 1);
    check("async_no_rsp", int'(rsp_valid0), 0);
    check("async_ready_low", int'(req_ready0), 0);
    saw_rsp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid0) saw_rsp = 1'b1;
    end
    reset = 1'b0;
    @(negedge clk);
    if (rsp_valid0) saw_rsp = 1'b1;
    check("aborted_no_rsp", int'(saw_rsp), 0);
    check("ready_after_abort", int'(req_ready0), 1);
    last_rd = 8'h00;
    cmd(0, 1'b1, 8'h40, 8'h77, last_rd, 1'b1);
    model_apply(1'b1, 8'h40, 8'h77);
    cmd(0, 1'b0, 8'h40, 8'h00, ref_mem[8'h40], 1'b1);
    @(negedge clk);
    sample(0, rdy, sv, sw, oe, we, rd, ad, dd);
    check("rsp_one_cycle", int'(sv), 0);
    check("rdata_held", int'(rd), 8'h77);

    check("invariants", mon_err, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
